// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes an ALU class/funct request, drives operands
// and operation select to an external combinational ALU, registers the result
// and holds it until the consumer takes it. Illegal R-type functs bypass the
// ALU and complete immediately with an error result.
module alu_issue_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_aluop,
   input  logic [5:0]       in_funct,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [3:0]       alu_op,
   input  logic [31:0]      alu_s,
   input  logic             alu_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_s,
   output logic             out_z,
   output logic             out_err,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t state, state_nxt;

   // Returns {legal, op}; only the R-type class can be illegal.
   function automatic logic [4:0] decode(input logic [1:0] aluop,
                                         input logic [5:0] funct);
      logic [4:0] r;
      r = {1'b1, OP_ADD};
      case (aluop)
         2'b00: r = {1'b1, OP_ADD};
         2'b01: r = {1'b1, OP_SUB};
         2'b11: r = {1'b1, OP_OR};
         default: begin
            case (funct)
               6'b100000: r = {1'b1, OP_ADD};
               6'b100010: r = {1'b1, OP_SUB};
               6'b100100: r = {1'b1, OP_AND};
               6'b100101: r = {1'b1, OP_OR};
               6'b100110: r = {1'b1, OP_XOR};
               6'b100111: r = {1'b1, OP_NOR};
               6'b101010: r = {1'b1, OP_SLT};
               default:   r = {1'b0, OP_ADD};
            endcase
         end
      endcase
      return r;
   endfunction

   logic       dec_legal;
   logic [3:0] dec_op;
   logic       accept;
   logic       consume;

   assign {dec_legal, dec_op} = decode(in_aluop, in_funct);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_ready & in_valid;
   assign consume   = out_valid & out_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: legal requests take one EXEC cycle, illegal go straight to DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = dec_legal ? EXEC : DONE;
         EXEC: state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand/op registers: loaded only on a legal accept, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= OP_AND;
      end else if (accept && dec_legal) begin
         alu_a  <= in_a;
         alu_b  <= in_b;
         alu_op <= dec_op;
      end
   end

   // Result registers: ALU capture at end of EXEC, fixed error result on illegal accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_s   <= '0;
         out_z   <= 1'b0;
         out_err <= 1'b0;
      end else if (state == EXEC) begin
         out_s   <= alu_s;
         out_z   <= alu_z;
         out_err <= 1'b0;
      end else if (accept && !dec_legal) begin
         out_s   <= '0;
         out_z   <= 1'b1;
         out_err <= 1'b1;
      end
   end

   // Completed-result counter, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       op_count <= '0;
      else if (consume) op_count <= op_count + CNT_W'(1);
   end

endmodule
